// File: rtl/rgmii_rx_clk_speed_detect.sv
// rgmii_rx_clk_speed_detect
// Measures the rise-to-rise period of the synchronized forwarded RX clock in clk_i cycles and
// reports a debounced link-speed setting (1000/100/10) or loss of clock on timeout.
// Optional build macro RX_SPEED_DETECT_ERRCNT_EN adds err_count_o, a saturating count of rises
// whose class disagreed with the locked setting.

module rgmii_rx_clk_speed_detect #(
   parameter int unsigned GIG_MAX_P    = 3,
   parameter int unsigned FAST_MAX_P   = 15,
   parameter int unsigned SLOW_MAX_P   = 150,
   parameter int unsigned TIMEOUT_P    = 255,
   parameter int unsigned STABLE_CNT_P = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       sample_i,
   output logic [1:0] clk_setting_o,
   output logic       valid_o,
   output logic       change_o
`ifdef RX_SPEED_DETECT_ERRCNT_EN
   ,
   output logic [7:0] err_count_o
`endif
);

   localparam int unsigned CntW   = $clog2(TIMEOUT_P + 1);
   localparam int unsigned MatchW = $clog2(STABLE_CNT_P + 1);

   localparam logic [1:0] Set1000 = 2'b00;
   localparam logic [1:0] Set100  = 2'b01;
   localparam logic [1:0] Set10   = 2'b10;
   localparam logic [1:0] SetNone = 2'b11;

   localparam logic [CntW-1:0]   CntMax    = CntW'(TIMEOUT_P);
   localparam logic [MatchW-1:0] MatchLock = MatchW'(STABLE_CNT_P);

   typedef enum logic [1:0] {
      StSearch,
      StMeasure,
      StLocked
   } state_e;

   // Map a measured period onto a speed class; out-of-range periods read as no clock.
   function automatic logic [1:0] classify(input logic [CntW-1:0] period);
      logic [31:0] p;
      p = 32'(period);
      if (p < 32'd2) begin
         classify = SetNone;
      end else if (p <= GIG_MAX_P) begin
         classify = Set1000;
      end else if (p <= FAST_MAX_P) begin
         classify = Set100;
      end else if (p <= SLOW_MAX_P) begin
         classify = Set10;
      end else begin
         classify = SetNone;
      end
   endfunction

   logic                sample_q;
   logic                rise;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                cnt_sat;
   logic                timeout;
   logic [1:0]          cls;

   state_e              state_q, state_d;
   logic [MatchW-1:0]   match_q, match_d;
   logic [1:0]          cand_q, cand_d;
   logic [1:0]          setting_q, setting_d;
   logic                valid_q, valid_d;
   logic                change_q, change_d;

   assign rise    = sample_i & ~sample_q;
   assign cnt_sat = (cnt_q == CntMax);
   // A rise in the saturation cycle takes priority; its period then classifies as no clock.
   assign timeout = cnt_sat & ~rise & (state_q != StSearch);
   assign cls     = classify(cnt_q);

   // Period counter: restarts at 1 on each rise, otherwise counts up and saturates.
   always_comb begin
      cnt_d = cnt_q;
      if (rise) begin
         cnt_d = CntW'(1);
      end else if (!cnt_sat) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Edge-detect register and period counter.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sample_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sample_q <= sample_i;
         cnt_q    <= cnt_d;
      end
   end

   // Search/measure/lock sequencing and output next-state.
   always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      cand_d    = cand_q;
      setting_d = setting_q;
      valid_d   = valid_q;
      change_d  = 1'b0;

      unique case (state_q)
         StSearch: begin
            // First rise only starts the period measurement.
            if (rise) begin
               state_d = StMeasure;
            end
         end

         StMeasure: begin
            if (timeout) begin
               state_d   = StSearch;
               setting_d = SetNone;
               valid_d   = 1'b0;
               cand_d    = SetNone;
               match_d   = '0;
            end else if (rise) begin
               if ((cls != SetNone) && (cls == cand_q)) begin
                  match_d = match_q + MatchW'(1);
               end else begin
                  cand_d  = cls;
                  match_d = (cls == SetNone) ? MatchW'(0) : MatchW'(1);
               end
               if (match_d == MatchLock) begin
                  // Old setting is held through re-measure; only a real change pulses.
                  change_d  = ~valid_q | (cand_d != setting_q);
                  setting_d = cand_d;
                  valid_d   = 1'b1;
                  state_d   = StLocked;
                  match_d   = '0;
               end
            end
         end

         StLocked: begin
            if (timeout) begin
               state_d   = StSearch;
               setting_d = SetNone;
               valid_d   = 1'b0;
               cand_d    = SetNone;
               match_d   = '0;
            end else if (rise && (cls != setting_q)) begin
               state_d = StMeasure;
               cand_d  = cls;
               match_d = (cls == SetNone) ? MatchW'(0) : MatchW'(1);
            end
         end

         default: begin
            state_d = StSearch;
         end
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StSearch;
         match_q   <= '0;
         cand_q    <= SetNone;
         setting_q <= SetNone;
         valid_q   <= 1'b0;
         change_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         cand_q    <= cand_d;
         setting_q <= setting_d;
         valid_q   <= valid_d;
         change_q  <= change_d;
      end
   end

   assign clk_setting_o = setting_q;
   assign valid_o       = valid_q;
   assign change_o      = change_q;

`ifdef RX_SPEED_DETECT_ERRCNT_EN
   logic [7:0] err_q, err_d;

   // valid_q is only set in LOCKED or in a re-measure that started from LOCKED.
   always_comb begin
      err_d = err_q;
      if (rise && valid_q && (cls != setting_q) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   // Disagreement counter, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count_o = err_q;
`endif

endmodule

// File: tb/tb_rgmii_rx_clk_speed_detect.sv
// Bench for rgmii_rx_clk_speed_detect: timestamp/queue reference model compared every cycle,
// plus directed phases with hand-computed literal expectations.

module tb_rgmii_rx_clk_speed_detect;

   localparam int GIG    = 3;
   localparam int FAST   = 15;
   localparam int SLOW   = 150;
   localparam int TMO    = 255;
   localparam int STABLE = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       sample;
   logic [1:0] clk_setting;
   logic       valid;
   logic       change;
`ifdef RX_SPEED_DETECT_ERRCNT_EN
   logic [7:0] err_count;
`endif

   rgmii_rx_clk_speed_detect #(
      .GIG_MAX_P    (GIG),
      .FAST_MAX_P   (FAST),
      .SLOW_MAX_P   (SLOW),
      .TIMEOUT_P    (TMO),
      .STABLE_CNT_P (STABLE)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .sample_i      (sample),
      .clk_setting_o (clk_setting),
      .valid_o       (valid),
      .change_o      (change)
`ifdef RX_SPEED_DETECT_ERRCNT_EN
      ,
      .err_count_o   (err_count)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int win_chg = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Period = cycles since the last rise (or since reset), capped at the timeout.
   // Classified periods since search/lock are kept in a queue; lock when its tail holds
   // STABLE equal valid classes.
   int         cyc = 0;
   int         m_ref;
   int         m_per;
   int         m_err;
   bit         m_ready = 1'b0;
   bit         m_prev;
   bit         m_rise;
   bit         m_search;
   bit         m_valid;
   bit         m_change;
   logic [1:0] m_setting;
   logic [1:0] m_cls;
   logic [1:0] m_hist[$];

   function automatic logic [1:0] class_of(input int p);
      if (p < 2) return 2'b11;
      if (p <= GIG) return 2'b00;
      if (p <= FAST) return 2'b01;
      if (p <= SLOW) return 2'b10;
      return 2'b11;
   endfunction

   function automatic bit tail_locks();
      int n;
      n = m_hist.size();
      if (n < STABLE) return 1'b0;
      if (m_hist[n-1] == 2'b11) return 1'b0;
      for (int i = 1; i < STABLE; i++) begin
         if (m_hist[n-1-i] != m_hist[n-1]) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin : ref_model
      if (reset === 1'b1) begin
         m_prev    = 1'b0;
         m_ref     = cyc + 1;
         m_search  = 1'b1;
         m_valid   = 1'b0;
         m_setting = 2'b11;
         m_change  = 1'b0;
         m_err     = 0;
         m_hist.delete();
         m_ready   = 1'b1;
      end else if (m_ready) begin
         m_change = 1'b0;
         m_per    = cyc - m_ref;
         if (m_per > TMO) m_per = TMO;
         m_rise = (sample === 1'b1) && !m_prev;
         m_prev = (sample === 1'b1);
         if (m_rise) begin
            m_ref = cyc;
            if (m_search) begin
               m_search = 1'b0;
               m_hist.delete();
            end else begin
               m_cls = class_of(m_per);
               if (m_valid && (m_cls != m_setting) && (m_err < 255)) m_err++;
               // Locked with no pending re-measure: matching rises are ignored.
               if (!(m_valid && (m_hist.size() == 0) && (m_cls == m_setting))) begin
                  m_hist.push_back(m_cls);
                  if (tail_locks()) begin
                     m_change  = !m_valid || (m_setting != m_cls);
                     m_setting = m_cls;
                     m_valid   = 1'b1;
                     m_hist.delete();
                  end
               end
            end
         end else if (!m_search && (m_per >= TMO)) begin
            m_search  = 1'b1;
            m_valid   = 1'b0;
            m_setting = 2'b11;
            m_hist.delete();
         end
      end
      cyc++;
   end

   // ---------------- per-cycle compare ----------------
   bit prev_change = 1'b0;

   always @(negedge clk) begin : compare
      if (m_ready) begin
         check("model_setting", 32'(clk_setting), 32'(m_setting));
         check("model_valid", 32'(valid), 32'(m_valid));
         check("model_change", 32'(change), 32'(m_change));
         check("change_back_to_back", 32'(change & prev_change), 32'd0);
`ifdef RX_SPEED_DETECT_ERRCNT_EN
         check("model_err_count", 32'(err_count), 32'(m_err));
`endif
         prev_change = (change === 1'b1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      if (change === 1'b1) win_chg++;
   endtask

   task automatic drive_period(input int hi, input int lo);
      sample = 1'b1;
      repeat (hi) tick();
      sample = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic sweep(input string name, input int hi, input int lo, input int exp_set);
      repeat (6) drive_period(hi, lo);
      check(name, 32'(clk_setting), 32'(exp_set));
      check({name, "_valid"}, 32'(valid), 32'd1);
   endtask

`ifdef RX_SPEED_DETECT_ERRCNT_EN
   int err0;
`endif

   initial begin
      reset  = 1'b1;
      sample = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Idle: no clock for 300 cycles.
      win_chg = 0;
      repeat (300) tick();
      check("idle_setting", 32'(clk_setting), 32'd3);
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_change_count", 32'(win_chg), 32'd0);

      // Period 2: lock one cycle after the 5th rise.
      repeat (4) drive_period(1, 1);
      check("gig_pre_lock_valid", 32'(valid), 32'd0);
      sample = 1'b1;
      tick();
      check("gig_lock_valid", 32'(valid), 32'd1);
      check("gig_lock_setting", 32'(clk_setting), 32'd0);
      check("gig_lock_change", 32'(change), 32'd1);
      sample = 1'b0;
      tick();
      check("gig_change_single", 32'(change), 32'd0);
      repeat (3) drive_period(1, 1);

      // Switch to period 100: setting holds through re-measure.
      repeat (4) drive_period(50, 50);
      check("to10_hold_setting", 32'(clk_setting), 32'd0);
      check("to10_hold_valid", 32'(valid), 32'd1);
      sample = 1'b1;
      tick();
      check("to10_setting", 32'(clk_setting), 32'd2);
      check("to10_change", 32'(change), 32'd1);
      repeat (49) tick();
      sample = 1'b0;
      repeat (50) tick();

      // Lock at 100M, then a single period-20 glitch.
      repeat (6) drive_period(5, 5);
      check("lock100_setting", 32'(clk_setting), 32'd1);
`ifdef RX_SPEED_DETECT_ERRCNT_EN
      err0 = int'(err_count);
`endif
      win_chg = 0;
      drive_period(5, 15);
      drive_period(5, 5);
      repeat (8) drive_period(5, 5);
      check("glitch_setting", 32'(clk_setting), 32'd1);
      check("glitch_valid", 32'(valid), 32'd1);
      check("glitch_change_count", 32'(win_chg), 32'd0);
`ifdef RX_SPEED_DETECT_ERRCNT_EN
      check("glitch_err_delta", 32'(int'(err_count) - err0), 32'd1);
`endif

      // Lock at 10M, then clock stuck high until timeout.
      repeat (6) drive_period(50, 50);
      check("lock10_setting", 32'(clk_setting), 32'd2);
      win_chg = 0;
      sample  = 1'b1;
      tick();
      repeat (254) tick();
      check("pre_timeout_valid", 32'(valid), 32'd1);
      check("pre_timeout_setting", 32'(clk_setting), 32'd2);
      tick();
      check("timeout_valid", 32'(valid), 32'd0);
      check("timeout_setting", 32'(clk_setting), 32'd3);
      check("timeout_change", 32'(change), 32'd0);
      check("timeout_change_count", 32'(win_chg), 32'd0);

      // Resume period 10: fresh lock with a change pulse.
      sample = 1'b0;
      repeat (5) tick();
      repeat (4) drive_period(5, 5);
      check("relock_pre_valid", 32'(valid), 32'd0);
      sample = 1'b1;
      tick();
      check("relock_valid", 32'(valid), 32'd1);
      check("relock_setting", 32'(clk_setting), 32'd1);
      check("relock_change", 32'(change), 32'd1);
      repeat (4) tick();
      sample = 1'b0;
      repeat (5) tick();

      // Lock at 1000M, then a one-cycle reset.
      repeat (6) drive_period(1, 1);
      check("gig2_setting", 32'(clk_setting), 32'd0);
      reset = 1'b1;
      tick();
      check("rst_setting", 32'(clk_setting), 32'd3);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_change", 32'(change), 32'd0);
`ifdef RX_SPEED_DETECT_ERRCNT_EN
      check("rst_err", 32'(err_count), 32'd0);
`endif
      reset = 1'b0;
      repeat (4) drive_period(1, 1);
      check("rst_relock_pre_valid", 32'(valid), 32'd0);
      sample = 1'b1;
      tick();
      check("rst_relock_valid", 32'(valid), 32'd1);
      check("rst_relock_setting", 32'(clk_setting), 32'd0);
      check("rst_relock_change", 32'(change), 32'd1);
      sample = 1'b0;
      tick();

      // Class boundaries.
      sweep("period3", 1, 2, 0);
      sweep("period4", 2, 2, 1);
      sweep("period15", 7, 8, 1);
      sweep("period16", 8, 8, 2);
      sweep("period150", 75, 75, 2);
      sweep("period151", 75, 76, 2);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
